lfsr_id_allocator: RTL and testbench

//  Parametrised random node-ID allocator for the router's packet controller.
//  A free-running Galois LFSR draws candidate IDs and skips reserved values.

---
 rtl/lfsr_id_allocator_pkg.sv | 19 +
 rtl/lfsr_id_allocator_lfsr_core.sv | 37 +++
 rtl/lfsr_id_allocator.sv | 138 +++++++++++++
 tb/tb_lfsr_id_allocator.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_id_allocator_pkg.sv
// Shared types for the random node-ID allocator: ID type, reserved values, FSM states.
package lfsr_id_allocator_pkg;

  localparam int NODE_ID_W = 8;

  typedef logic [NODE_ID_W-1:0] node_id_t;

  localparam node_id_t ID_NONE      = '0;
  localparam node_id_t ID_BROADCAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    OFFER,
    BACKOFF,
    FAIL
  } id_alloc_state_e;

endpackage

// File: rtl/lfsr_id_allocator_lfsr_core.sv
// Free-running Galois LFSR with seed load; a zero seed falls back to SEED so the
// register can never lock up in the all-zero state.
module lfsr_core #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_state
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_state >> 1;
    if (r_state[0]) begin
      w_next = w_next ^ TAPS;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= (i_load_val == '0) ? SEED : i_load_val;
    end else begin
      r_state <= w_next;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/lfsr_id_allocator.sv
// Random node-ID allocator: draws non-reserved IDs from an LFSR, offers them with
// valid/ack, and on collision backs off a random time and redraws up to MAX_RETRY times.
module lfsr_id_allocator
  import lfsr_id_allocator_pkg::*;
#(
  parameter int                    ID_WIDTH     = 8,
  parameter int                    LFSR_WIDTH   = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS    = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] SEED         = 16'hACE1,
  parameter int                    BACKOFF_BITS = 4,
  parameter int                    MAX_RETRY    = 7
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_seed_load,
  input  logic [LFSR_WIDTH-1:0]             i_seed_in,
  input  logic                              i_req,
  input  logic                              i_id_ack,
  input  logic                              i_collision,
  output logic [ID_WIDTH-1:0]               o_id,
  output logic                              o_id_valid,
  output logic                              o_busy,
  output logic                              o_fail,
  output logic [$clog2(MAX_RETRY+2)-1:0]    o_retry_cnt
);

  // One extra count value so the collision that exceeds MAX_RETRY is still visible.
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  id_alloc_state_e         r_state, w_state_nxt;
  logic [ID_WIDTH-1:0]     r_id, w_id_nxt;
  logic                    r_id_valid, w_id_valid_nxt;
  logic [RETRY_W-1:0]      r_retry_cnt, w_retry_nxt;
  logic [BACKOFF_BITS-1:0] r_bo_cnt, w_bo_nxt;

  logic [LFSR_WIDTH-1:0]   w_lfsr;
  logic [ID_WIDTH-1:0]     w_cand;
  logic                    w_reserved;
  logic [RETRY_W-1:0]      w_retry_inc;
  logic                    w_unused_lfsr;

  lfsr_core #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (LFSR_TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (i_seed_load),
    .i_load_val (i_seed_in),
    .o_state    (w_lfsr)
  );

  assign w_cand        = w_lfsr[ID_WIDTH-1:0];
  assign w_reserved    = (w_cand == {ID_WIDTH{1'b0}}) || (w_cand == {ID_WIDTH{1'b1}});
  assign w_retry_inc   = r_retry_cnt + RETRY_W'(1);
  assign w_unused_lfsr = ^w_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_id        <= '0;
      r_id_valid  <= 1'b0;
      r_retry_cnt <= '0;
      r_bo_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_id        <= w_id_nxt;
      r_id_valid  <= w_id_valid_nxt;
      r_retry_cnt <= w_retry_nxt;
      r_bo_cnt    <= w_bo_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_id_nxt       = r_id;
    w_id_valid_nxt = r_id_valid;
    w_retry_nxt    = r_retry_cnt;
    w_bo_nxt       = r_bo_cnt;
    case (r_state)
      IDLE: begin
        if (i_req) begin
          w_state_nxt = DRAW;
          w_retry_nxt = '0;
        end
      end
      DRAW: begin
        if (!w_reserved) begin
          w_id_nxt       = w_cand;
          w_id_valid_nxt = 1'b1;
          w_state_nxt    = OFFER;
        end
      end
      // Collision takes precedence over a simultaneous ack.
      OFFER: begin
        if (i_collision) begin
          w_id_valid_nxt = 1'b0;
          w_retry_nxt    = w_retry_inc;
          if (w_retry_inc > RETRY_W'(MAX_RETRY)) begin
            w_state_nxt = FAIL;
          end else begin
            w_state_nxt = BACKOFF;
            w_bo_nxt    = w_lfsr[BACKOFF_BITS-1:0];
          end
        end else if (i_id_ack) begin
          w_id_valid_nxt = 1'b0;
          w_state_nxt    = IDLE;
        end
      end
      BACKOFF: begin
        if (r_bo_cnt == '0) begin
          w_state_nxt = DRAW;
        end else begin
          w_bo_nxt = r_bo_cnt - BACKOFF_BITS'(1);
        end
      end
      FAIL: begin
        w_id_valid_nxt = 1'b0;
        if (i_req) begin
          w_state_nxt = DRAW;
          w_retry_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = IDLE;
        w_id_valid_nxt = 1'b0;
      end
    endcase
  end

  assign o_id        = r_id;
  assign o_id_valid  = r_id_valid;
  assign o_busy      = (r_state != IDLE) && (r_state != FAIL);
  assign o_fail      = (r_state == FAIL);
  assign o_retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_lfsr_id_allocator.sv
// Directed self-checking bench for lfsr_id_allocator with default parameters.
module tb_lfsr_id_allocator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seedLoad = 1'b0;
  logic [15:0] seedIn = 16'h0000;
  logic        req = 1'b0;
  logic        idAck = 1'b0;
  logic        collision = 1'b0;
  logic [7:0]  id;
  logic        idValid;
  logic        busy;
  logic        fail;
  logic [3:0]  retryCnt;
  logic [15:0] dutLfsr;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  lfsr_id_allocator dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_seed_load (seedLoad),
    .i_seed_in   (seedIn),
    .i_req       (req),
    .i_id_ack    (idAck),
    .i_collision (collision),
    .o_id        (id),
    .o_id_valid  (idValid),
    .o_busy      (busy),
    .o_fail      (fail),
    .o_retry_cnt (retryCnt)
  );

  assign dutLfsr = dut.w_lfsr;

  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    nCompared++;
    if (dutLfsr !== 16'hACE1) begin
      nMismatched++;
      $display("[TB] FAIL reset_lfsr: got %h expected %h", dutLfsr, 16'hACE1);
    end
    nCompared++;
    if ({idValid, busy, fail, retryCnt, id} !== {3'b000, 4'd0, 8'h00}) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got v%b b%b f%b r%0d id%h expected all zero",
               idValid, busy, fail, retryCnt, id);
    end
    rst = 1'b0;
    tick;
    nCompared++;
    if (dutLfsr !== 16'hE270) begin
      nMismatched++;
      $display("[TB] FAIL lfsr_first_step: got %h expected %h", dutLfsr, 16'hE270);
    end
  endtask

  task automatic test_seed_load;
    seedLoad = 1'b1;
    seedIn = 16'h0000;
    tick;
    nCompared++;
    if (dutLfsr !== 16'hACE1) begin
      nMismatched++;
      $display("[TB] FAIL seed_zero: got %h expected %h", dutLfsr, 16'hACE1);
    end
    seedIn = 16'h0001;
    tick;
    nCompared++;
    if (dutLfsr !== 16'h0001) begin
      nMismatched++;
      $display("[TB] FAIL seed_0001: got %h expected %h", dutLfsr, 16'h0001);
    end
    seedLoad = 1'b0;
    tick;
    nCompared++;
    if (dutLfsr !== 16'hB400) begin
      nMismatched++;
      $display("[TB] FAIL seed_advance: got %h expected %h", dutLfsr, 16'hB400);
    end
  endtask

  task automatic test_idle_ignore;
    idAck = 1'b1;
    collision = 1'b1;
    tick;
    idAck = 1'b0;
    collision = 1'b0;
    nCompared++;
    if ({idValid, busy, fail, retryCnt} !== {3'b000, 4'd0}) begin
      nMismatched++;
      $display("[TB] FAIL idle_ignore: got v%b b%b f%b r%0d expected 0 0 0 0",
               idValid, busy, fail, retryCnt);
    end
  endtask

  task automatic test_single_offer;
    seedLoad = 1'b1;
    seedIn = 16'h1234;
    req = 1'b1;
    tick;
    seedLoad = 1'b0;
    req = 1'b0;
    nCompared++;
    if ({idValid, busy} !== 2'b01) begin
      nMismatched++;
      $display("[TB] FAIL offer_latency1: got v%b b%b expected v0 b1", idValid, busy);
    end
    tick;
    nCompared++;
    if ({idValid, id} !== {1'b1, 8'h34}) begin
      nMismatched++;
      $display("[TB] FAIL offer_id: got v%b id%h expected v1 id34", idValid, id);
    end
    tick;
    tick;
    nCompared++;
    if ({idValid, busy, id} !== {2'b11, 8'h34}) begin
      nMismatched++;
      $display("[TB] FAIL offer_hold: got v%b b%b id%h expected v1 b1 id34", idValid, busy, id);
    end
    idAck = 1'b1;
    tick;
    idAck = 1'b0;
    nCompared++;
    if ({idValid, busy, fail, id} !== {3'b000, 8'h34}) begin
      nMismatched++;
      $display("[TB] FAIL ack_release: got v%b b%b f%b id%h expected 0 0 0 id34",
               idValid, busy, fail, id);
    end
  endtask

  task automatic test_reserved_skip;
    // Seed 00FF: first candidate is broadcast, next state B47F offers 7F.
    seedLoad = 1'b1;
    seedIn = 16'h00FF;
    req = 1'b1;
    tick;
    seedLoad = 1'b0;
    req = 1'b0;
    tick;
    nCompared++;
    if ({idValid, busy} !== 2'b01) begin
      nMismatched++;
      $display("[TB] FAIL skip_ff_hold: got v%b b%b expected v0 b1", idValid, busy);
    end
    tick;
    nCompared++;
    if ({idValid, id} !== {1'b1, 8'h7F}) begin
      nMismatched++;
      $display("[TB] FAIL skip_ff_id: got v%b id%h expected v1 id7f", idValid, id);
    end
    idAck = 1'b1;
    tick;
    idAck = 1'b0;
    // Seed 1200 -> 0900 -> 0480: two zero candidates, then 80.
    seedLoad = 1'b1;
    seedIn = 16'h1200;
    req = 1'b1;
    tick;
    seedLoad = 1'b0;
    req = 1'b0;
    tick;
    tick;
    nCompared++;
    if ({idValid, busy} !== 2'b01) begin
      nMismatched++;
      $display("[TB] FAIL skip_00_hold: got v%b b%b expected v0 b1", idValid, busy);
    end
    tick;
    nCompared++;
    if ({idValid, id} !== {1'b1, 8'h80}) begin
      nMismatched++;
      $display("[TB] FAIL skip_00_id: got v%b id%h expected v1 id80", idValid, id);
    end
    idAck = 1'b1;
    tick;
    idAck = 1'b0;
  endtask

  task automatic test_collision_retry;
    logic [15:0] expLfsr;
    logic [7:0]  cand;
    int          edges;
    int          bo;
    seedLoad = 1'b1;
    seedIn = 16'hBEEF;
    req = 1'b1;
    tick;
    seedLoad = 1'b0;
    req = 1'b0;
    expLfsr = 16'hBEEF;
    for (int round = 1; round <= 8; round++) begin
      nCompared++;
      if (dutLfsr !== expLfsr) begin
        nMismatched++;
        $display("[TB] FAIL retry_lfsr round %0d: got %h expected %h", round, dutLfsr, expLfsr);
      end
      edges = 0;
      do begin
        cand = expLfsr[7:0];
        expLfsr = lfsrStep(expLfsr);
        edges++;
      end while (cand == 8'h00 || cand == 8'hFF);
      for (int e = 1; e < edges; e++) begin
        tick;
        nCompared++;
        if (idValid !== 1'b0) begin
          nMismatched++;
          $display("[TB] FAIL retry_draw round %0d: got v%b expected v0", round, idValid);
        end
      end
      tick;
      nCompared++;
      if ({idValid, id} !== {1'b1, cand}) begin
        nMismatched++;
        $display("[TB] FAIL retry_offer round %0d: got v%b id%h expected v1 id%h",
                 round, idValid, id, cand);
      end
      collision = 1'b1;
      bo = int'(expLfsr[3:0]);
      tick;
      collision = 1'b0;
      expLfsr = lfsrStep(expLfsr);
      nCompared++;
      if (retryCnt !== 4'(round)) begin
        nMismatched++;
        $display("[TB] FAIL retry_count round %0d: got %0d expected %0d", round, retryCnt, round);
      end
      if (round < 8) begin
        for (int b = 0; b <= bo; b++) begin
          nCompared++;
          if ({idValid, busy, fail} !== 3'b010) begin
            nMismatched++;
            $display("[TB] FAIL backoff round %0d cycle %0d: got v%b b%b f%b expected 0 1 0",
                     round, b, idValid, busy, fail);
          end
          tick;
          expLfsr = lfsrStep(expLfsr);
        end
      end else begin
        nCompared++;
        if ({idValid, busy, fail} !== 3'b001) begin
          nMismatched++;
          $display("[TB] FAIL fail_flags: got v%b b%b f%b expected 0 0 1", idValid, busy, fail);
        end
      end
    end
    req = 1'b1;
    tick;
    req = 1'b0;
    expLfsr = lfsrStep(expLfsr);
    nCompared++;
    if ({fail, busy, retryCnt} !== {2'b01, 4'd0}) begin
      nMismatched++;
      $display("[TB] FAIL fail_clear: got f%b b%b r%0d expected f0 b1 r0", fail, busy, retryCnt);
    end
    edges = 0;
    do begin
      cand = expLfsr[7:0];
      expLfsr = lfsrStep(expLfsr);
      edges++;
    end while (cand == 8'h00 || cand == 8'hFF);
    repeat (edges) tick;
    nCompared++;
    if ({idValid, id} !== {1'b1, cand}) begin
      nMismatched++;
      $display("[TB] FAIL refail_offer: got v%b id%h expected v1 id%h", idValid, id, cand);
    end
    idAck = 1'b1;
    tick;
    idAck = 1'b0;
  endtask

  task automatic test_ack_collision_reset;
    // Offer at lfsr 091A leaves a backoff load of 10, so reset lands inside BACKOFF.
    seedLoad = 1'b1;
    seedIn = 16'h1234;
    req = 1'b1;
    tick;
    seedLoad = 1'b0;
    req = 1'b0;
    tick;
    idAck = 1'b1;
    collision = 1'b1;
    tick;
    idAck = 1'b0;
    collision = 1'b0;
    nCompared++;
    if ({idValid, busy, fail, retryCnt} !== {3'b010, 4'd1}) begin
      nMismatched++;
      $display("[TB] FAIL ack_collision: got v%b b%b f%b r%0d expected 0 1 0 1",
               idValid, busy, fail, retryCnt);
    end
    tick;
    rst = 1'b1;
    tick;
    nCompared++;
    if ({idValid, busy, fail, retryCnt, id} !== {3'b000, 4'd0, 8'h00}) begin
      nMismatched++;
      $display("[TB] FAIL midop_reset: got v%b b%b f%b r%0d id%h expected all zero",
               idValid, busy, fail, retryCnt, id);
    end
    nCompared++;
    if (dutLfsr !== 16'hACE1) begin
      nMismatched++;
      $display("[TB] FAIL midop_reset_lfsr: got %h expected %h", dutLfsr, 16'hACE1);
    end
    rst = 1'b0;
    tick;
    tick;
    nCompared++;
    if ({idValid, busy} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL post_reset_idle: got v%b b%b expected v0 b0", idValid, busy);
    end
  endtask

  initial begin
    test_reset;
    test_seed_load;
    test_idle_ignore;
    test_single_offer;
    test_reserved_skip;
    test_collision_retry;
    test_ack_collision_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
